// File: rtl/aes128_decrypt_iterative.sv
// ---------------------------------------------------------------------------
// aes128_decrypt_iterative
//
// Iterative AES-128 decryptor (InvCipher) that completes one round per clock.
// The key schedule is first run forward to reach round key 10, then run
// backwards on the fly so each round derives the key it needs from the one
// before. The last expanded key and its round-10 key are kept so that a job
// with the same key can skip the forward expansion.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous, active-high; clears all state and the key cache
//   start_i      request pulse, only sampled while busy_o is low
//   data_i       ciphertext, byte 0 in [127:120]
//   key_i        cipher key, same byte order
//   out_o        plaintext, valid with done_o and held until the next job ends
//   done_o       one-cycle pulse marking out_o valid
//   key_ready_o  cached round-10 key is valid for the held key
//   busy_o       high while expanding the key or running rounds
// ---------------------------------------------------------------------------
module aes128_decrypt_iterative #(
   parameter bit CACHE_KEY = 1'b1
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic [127:0] out_o,
   output logic         done_o,
   output logic         key_ready_o,
   output logic         busy_o
);

   typedef enum logic [1:0] {IDLE, KEXP, ROUND} fsmState_t;

   fsmState_t    state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] rk_q, rk_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] kreg_q, kreg_d;
   logic [127:0] rk10_q, rk10_d;
   logic [127:0] dataReg_q, dataReg_d;
   logic [127:0] out_q, out_d;
   logic         keyReady_q, keyReady_d;
   logic         done_q, done_d;

   logic [7:0]   rcCur;
   logic [127:0] rkFwd;
   logic [127:0] rkPrev;
   logic [127:0] invBase;
   logic [127:0] roundOut;
   logic         keyHit;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // Multiply by a 4-bit constant (09/0b/0d/0e) using a doubling chain.
   function automatic logic [7:0] gfMulConst(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
             (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gfMul(p, p);
         r = gfMul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gfInv(b);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] invSbox(input logic [7:0] s);
      return gfInv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] subRotWord(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] nextFwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one forward step: the later words are recovered first because
   // w0 of the previous key depends on the recovered w3.
   function automatic logic [127:0] prevKey(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] v0, v1, v2, v3;
      v3 = k[31:0] ^ k[63:32];
      v2 = k[63:32] ^ k[95:64];
      v1 = k[95:64] ^ k[127:96];
      v0 = k[127:96] ^ subRotWord(v3) ^ {rc, 24'h0};
      return {v0, v1, v2, v3};
   endfunction

   // Byte (col*4 + row) sits at [127-8*(col*4+row) -: 8]; row r rotates right by r.
   function automatic logic [127:0] invShiftRows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(c*4+row) -: 8] = s[127-8*(((c-row)&3)*4+row) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] invSubBytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = invSbox(s[127-8*i -: 8]);
      return r;
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = gfMulConst(a0, 4'he) ^ gfMulConst(a1, 4'hb) ^
                            gfMulConst(a2, 4'hd) ^ gfMulConst(a3, 4'h9);
         r[119-32*c -: 8] = gfMulConst(a0, 4'h9) ^ gfMulConst(a1, 4'he) ^
                            gfMulConst(a2, 4'hb) ^ gfMulConst(a3, 4'hd);
         r[111-32*c -: 8] = gfMulConst(a0, 4'hd) ^ gfMulConst(a1, 4'h9) ^
                            gfMulConst(a2, 4'he) ^ gfMulConst(a3, 4'hb);
         r[103-32*c -: 8] = gfMulConst(a0, 4'hb) ^ gfMulConst(a1, 4'hd) ^
                            gfMulConst(a2, 4'h9) ^ gfMulConst(a3, 4'he);
      end
      return r;
   endfunction

   // Shared round datapath. The same round counter picks the rcon for both
   // the forward expansion and the reverse schedule; the final round skips
   // InvMixColumns.
   always_comb begin
      rcCur    = rcon(rnd_q);
      rkFwd    = nextFwd(rk_q, rcCur);
      rkPrev   = prevKey(rk_q, rcCur);
      invBase  = invSubBytes(invShiftRows(st_q)) ^ rkPrev;
      roundOut = (rnd_q == 4'd1) ? invBase : invMixColumns(invBase);
      keyHit   = CACHE_KEY && keyReady_q && (key_i == kreg_q);
   end

   // Next-state logic. Every register holds by default and done_d defaults
   // low so done_o can only ever be a single-cycle pulse. A cache hit jumps
   // straight into the rounds using the stored round-10 key.
   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      rk_d       = rk_q;
      rnd_d      = rnd_q;
      kreg_d     = kreg_q;
      rk10_d     = rk10_q;
      dataReg_d  = dataReg_q;
      out_d      = out_q;
      keyReady_d = keyReady_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (keyHit) begin
                  rk_d    = rk10_q;
                  st_d    = data_i ^ rk10_q;
                  rnd_d   = 4'd10;
                  state_d = ROUND;
               end else begin
                  kreg_d     = key_i;
                  rk_d       = key_i;
                  dataReg_d  = data_i;
                  keyReady_d = 1'b0;
                  rnd_d      = 4'd1;
                  state_d    = KEXP;
               end
            end
         end
         KEXP: begin
            rk_d = rkFwd;
            if (rnd_q == 4'd10) begin
               rk10_d     = rkFwd;
               keyReady_d = 1'b1;
               st_d       = dataReg_q ^ rkFwd;
               rnd_d      = 4'd10;
               state_d    = ROUND;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         ROUND: begin
            rk_d = rkPrev;
            st_d = roundOut;
            if (rnd_q == 4'd1) begin
               out_d   = roundOut;
               done_d  = 1'b1;
               rnd_d   = 4'd0;
               state_d = IDLE;
            end else begin
               rnd_d = rnd_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset also invalidates the
   // key cache so the next job always expands the key again.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         st_q       <= '0;
         rk_q       <= '0;
         rnd_q      <= '0;
         kreg_q     <= '0;
         rk10_q     <= '0;
         dataReg_q  <= '0;
         out_q      <= '0;
         keyReady_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         st_q       <= st_d;
         rk_q       <= rk_d;
         rnd_q      <= rnd_d;
         kreg_q     <= kreg_d;
         rk10_q     <= rk10_d;
         dataReg_q  <= dataReg_d;
         out_q      <= out_d;
         keyReady_q <= keyReady_d;
         done_q     <= done_d;
      end
   end

   assign out_o       = out_q;
   assign done_o      = done_q;
   assign key_ready_o = keyReady_q;
   assign busy_o      = (state_q != IDLE);

endmodule
